csa_accumulator: RTL and testbench
==================================

// Module: csa_accumulator
// PURPOSE
//  Downstream consumer of the 4-bit carry-save adder stage. Accumulates a stream of WIDTH-bit
//  operands into a redundant carry-save pair (sum/carry registers), one operand per cycle, with
//  no carry propagation in the loop. On the last operand, resolves the pair with a multi-cycle
//  CHUNK-bit carry-propagate adder and presents the binary total with a valid/ready handshake.
// PARAMETERS
//  WIDTH    4   operand width (matches the CSA stage operand width)
//  ACC_W    12  accumulator/result width; total is modulo 2^ACC_W; must be a multiple of CHUNK
//  CHUNK    4   bits resolved per cycle by the final carry-propagate adder
//  COUNT_W  8   operand-count width; saturates at 2^COUNT_W-1
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        synchronous reset, active-high
//  in_valid   in   1        operand valid
//  in_ready   out  1        block accepts an operand this cycle
//  in_data    in   WIDTH    operand, unsigned, zero-extended to ACC_W
//  in_last    in   1        qualifies in_data as the final operand of a group
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  out_sum    out  ACC_W    resolved total, modulo 2^ACC_W
//  out_count  out  COUNT_W  operands in the group, saturating
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge, any state incl. mid-RESOLVE/OUTPUT): state=ACCUM, s=0, c=0,
//    count=0, out_sum=0, out_count=0, out_valid=0, in_ready=1 after the edge. Group in progress discarded.
//  - States: ACCUM -> RESOLVE -> OUTPUT -> ACCUM.
//  - ACCUM: in_ready=1, out_valid=0. Accept when in_valid&&in_ready at edge:
//      d=zext(in_data); s<=s^c^d; c<=((s&c)|(s&d)|(c&d))<<1, truncated to ACC_W (carry out of
//      MSB dropped); count<=count+1, holding at 2^COUNT_W-1. If in_last: go RESOLVE, chunk idx=0, cin=0.
//    No accept when in_valid=0; in_last ignored without in_valid.
//  - RESOLVE: in_ready=0, out_valid=0. N=ACC_W/CHUNK edges; edge i computes
//      {cin,res[i*CHUNK+:CHUNK]} <= s[i*CHUNK+:CHUNK]+c[i*CHUNK+:CHUNK]+cin, LSB chunk first.
//    Final carry-out discarded. After edge N: go OUTPUT, out_sum=res, out_count=count.
//  - Latency: out_valid rises N edges after the edge that accepted the in_last beat
//    (default N=3). Throughput: one group per (beats + N + 1) cycles min.
//  - OUTPUT: out_valid=1, in_ready=0; out_sum/out_count held stable until out_valid&&out_ready
//    at an edge, then s=0, c=0, count=0, go ACCUM (out_valid=0 next cycle; out_sum keeps last value).
//    out_ready may be high before out_valid; no combinational path from out_ready to in_ready.
//  - Single-beat group (in_last on first beat) legal: out_sum=in_data, out_count=1.
//  - Invariant in ACCUM: (s+c) mod 2^ACC_W equals the running sum mod 2^ACC_W.
// TESTING
//  (defaults) 1. Reset, beats 1111,1111,1111(last) -> after 3 edges out_valid=1, out_sum=12'h02D, out_count=3.
//  2. Beats 0101,1010,1100(last), out_ready=1 -> out_sum=12'h01B, out_count=3; ACCUM next cycle with s=c=0.
//  3. 274 beats of 1111, last on 274th -> out_sum=12'h00E (4110 mod 4096), out_count=8'hFF (saturated).
//  4. Single beat 0000(last), out_ready=0 for 5 cycles -> out_valid held, out_sum=0, out_count=1,
//     in_ready=0 throughout; in_valid beats during OUTPUT not accepted; release -> ACCUM.
//  5. Beats 1000,0100(last), rst=1 on second RESOLVE edge -> out_valid never rises; next group
//     0010(last) -> out_sum=12'h002, out_count=1.
//  6. Random gaps on in_valid over 20-beat groups vs. reference model sum -> exact match each group.

Source files
------------

// File: rtl/csa_accumulator.sv
// Carry-save accumulator: sums a stream of operands into a redundant s/c pair, then
// resolves the pair with a chunked multi-cycle carry-propagate adder and hands off the total.
module csa_accumulator #(
    parameter int WIDTH   = 4,
    parameter int ACC_W   = 12,
    parameter int CHUNK   = 4,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic [COUNT_W-1:0] out_count
);

    localparam int NCHUNK = ACC_W / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0]   s, c, d, s_nxt, c_nxt, res, res_nxt;
    logic [COUNT_W-1:0] count;
    logic [IDX_W-1:0]   idx;
    logic               cin;
    logic [CHUNK:0]     csum;
    logic               accept, last_chunk, out_fire;

    always_comb begin
        d     = ACC_W'(in_data);
        s_nxt = s ^ c ^ d;
        // Majority carries shift up one place; the carry out of the MSB is dropped.
        c_nxt = ((s & c) | (s & d) | (c & d)) << 1;
        csum  = {1'b0, s[idx*CHUNK +: CHUNK]} + {1'b0, c[idx*CHUNK +: CHUNK]}
              + (CHUNK + 1)'(cin);
        res_nxt = res;
        res_nxt[idx*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        last_chunk = (idx == IDX_W'(NCHUNK - 1));
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = RESOLVE;
            end
            RESOLVE: begin
                if (last_chunk) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
        accept   = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            c         <= '0;
            count     <= '0;
            res       <= '0;
            idx       <= '0;
            cin       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        s <= s_nxt;
                        c <= c_nxt;
                        if (count != '1) count <= count + 1'b1;
                        if (in_last) begin
                            idx <= '0;
                            cin <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    res <= res_nxt;
                    cin <= csum[CHUNK];
                    idx <= idx + 1'b1;
                    // The top chunk is merged straight into the result so it is ready on entry to OUTPUT.
                    if (last_chunk) begin
                        out_sum   <= res_nxt;
                        out_count <= count;
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        s     <= '0;
                        c     <= '0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: randomized/directed groups, an arithmetic
// reference model feeding a scoreboard, and an independent output monitor.
module tb_csa_accumulator;

    localparam int WIDTH   = 4;
    localparam int ACC_W   = 12;
    localparam int CHUNK   = 4;
    localparam int COUNT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [COUNT_W-1:0] out_count;

    csa_accumulator #(
        .WIDTH  (WIDTH),
        .ACC_W  (ACC_W),
        .CHUNK  (CHUNK),
        .COUNT_W(COUNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected results: {count, sum}
    logic [COUNT_W+ACC_W-1:0] sb[$];

    // Reference model state: plain integer running total and beat count.
    int model_acc = 0;
    int model_n   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push();
        int cnt;
        cnt = (model_n > 255) ? 255 : model_n;
        sb.push_back({COUNT_W'(cnt), ACC_W'(model_acc % 4096)});
        model_acc = 0;
        model_n   = 0;
    endtask

    // Presents one beat and holds it until accepted; returns just after the accepting edge.
    task automatic beat(input logic [WIDTH-1:0] dat, input logic last);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = dat;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_accept_timeout: in_ready stayed 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        model_acc = model_acc + int'(dat);
        model_n   = model_n + 1;
        if (last) model_push();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom);
            @(posedge clk);
            #1;
        end
        in_last = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results pending expected 0", sb.size());
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        logic [COUNT_W+ACC_W-1:0] exp;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: sum 0x%0h count %0d with empty scoreboard",
                         out_sum, out_count);
            end else begin
                exp = sb.pop_front();
                chk("out_sum", 32'(out_sum), 32'(exp[ACC_W-1:0]));
                chk("out_count", 32'(out_count), 32'(exp[COUNT_W+ACC_W-1:ACC_W]));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_sum", 32'(out_sum), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        @(posedge clk);
        #1;

        // Three 1111 beats; result must appear exactly three edges after the last beat.
        beat(4'hF, 1'b0);
        beat(4'hF, 1'b0);
        beat(4'hF, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("latency_out_valid", 32'(out_valid), (k == 3) ? 32'd1 : 32'd0);
            chk("resolve_in_ready", 32'(in_ready), (k == 3) ? 32'd0 : 32'd0);
        end
        @(posedge clk);
        #1;
        drain();

        beat(4'h5, 1'b0);
        beat(4'hA, 1'b0);
        beat(4'hC, 1'b1);
        drain();
        @(negedge clk);
        chk("accum_after_release", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Saturating count and modulo total.
        for (int i = 0; i < 274; i++) beat(4'hF, (i == 273) ? 1'b1 : 1'b0);
        drain();

        // Held result under back-pressure, with beats offered that must be refused.
        out_ready = 1'b0;
        beat(4'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("single_beat_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 4'hF;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_sum", 32'(out_sum), 32'd0);
            chk("hold_out_count", 32'(out_count), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset on the second RESOLVE edge discards the group.
        beat(4'h8, 1'b0);
        beat(4'h4, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("aborted_out_valid", 32'(out_valid), 32'd0);
        end
        chk("aborted_in_ready", 32'(in_ready), 32'd1);
        chk("aborted_out_sum", 32'(out_sum), 32'd0);
        @(posedge clk);
        #1;
        beat(4'h2, 1'b1);
        drain();

        // Random 20-beat groups with idle gaps and in_last noise between beats.
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < 20; i++) begin
                idle(int'($urandom_range(0, 3)));
                beat(4'($urandom), (i == 19) ? 1'b1 : 1'b0);
            end
        end
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
